// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Also exports scan-code prefixes used by downstream consumers.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    STOP   = 2'b11
  } ps2_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers and a sticky overflow flag.
// The head byte reads as zero while the FIFO is empty.
module ps2_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow
);
  import ps2_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [7:0]  mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop frees the slot the simultaneous push needs.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
      if (push && !do_push)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a byte FIFO.
// Define PS2_RX_TIMEOUT_EN to abort stalled partial frames.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);
  import ps2_pkg::*;

  logic       clk_s1, clk_s2, clk_s3;
  logic       dat_s1, dat_s2;
  logic       fall;

  ps2_state_e state, state_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, shreg_n;
  logic       par_bit, par_n;
  logic       push;
  logic       err_n;
  logic       tmo;
  logic       empty;
  logic       full_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign tmo = !fall && (state != IDLE) &&
               (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tcnt <= '0;
    else if (state == IDLE || fall || tmo)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end
`else
  logic unused_to;
  assign tmo       = 1'b0;
  assign unused_to = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      par_bit   <= par_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par_bit;
    push     = 1'b0;
    err_n    = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_n  = DATA;
            bitcnt_n = '0;
          end
        end
        DATA: begin
          shreg_n[bitcnt] = dat_s2;
          bitcnt_n        = bitcnt + 3'd1;
          if (bitcnt == 3'd7)
            state_n = PARITY;
        end
        PARITY: begin
          par_n   = dat_s2;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          // Odd parity: data plus parity bit has odd weight.
          if (dat_s2 && ^{shreg, par_bit})
            push = 1'b1;
          else
            err_n = 1'b1;
        end
      endcase
    end else if (tmo) begin
      state_n  = IDLE;
      bitcnt_n = '0;
      err_n    = 1'b1;
    end
  end

  ps2_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .din     (shreg),
    .pop     (~nextdata_n),
    .dout    (data),
    .empty   (empty),
    .full    (full_unused),
    .overflow(overflow)
  );

  assign ready = ~empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo with a queue-based reference model.
// Build with PS2_RX_TIMEOUT_EN to also exercise the frame timeout.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO = 300;
`else
  localparam int TO = 50000;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap[$];
  int         pop_cycles = 0;
  int         err_cnt = 0;

  ps2_rx_fifo #(
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready && !nextdata_n) begin
      cap.push_back(data);
      pop_cycles++;
    end
    if (frame_err)
      err_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(
    input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~^b ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    int ph;
    for (int i = 0; i < n; i++) begin
      ph = $urandom_range(5, 9);
      ps2_data = f[i];
      cyc(ph);
      ps2_clk = 1'b0;
      cyc(ph);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(
    input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(mk(b, bad_par, bad_stop), 11);
    cyc(8);
  endtask

  task automatic pop1();
    nextdata_n = 1'b0;
    cyc(1);
    nextdata_n = 1'b1;
    cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    nextdata_n = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    cap.delete();
    pop_cycles = 0;
    err_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(2);
    checks++;
    if (ready !== 1'b0 || data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out ready=%b data=%h want 0/00",
               ready, data);
    end
    checks++;
    if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ovf=%b ferr=%b want 0/0",
               overflow, frame_err);
    end
    do_reset();
  endtask

  task automatic test_hold_pop();
    send(8'h1C, 0, 0);
    cyc(10);
    checks++;
    if (ready !== 1'b1 || data !== 8'h1C) begin
      errors++;
      $display("FAIL hold ready=%b data=%h want 1/1c", ready, data);
    end
    pop1();
    checks++;
    if (ready !== 1'b0 || data !== 8'h00) begin
      errors++;
      $display("FAIL after_pop ready=%b data=%h want 0/00",
               ready, data);
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp[$];
    logic [7:0] b;
    do_reset();
    nextdata_n = 1'b0;
    exp = '{8'hF0, 8'h1C};
    for (int i = 0; i < 6; i++)
      exp.push_back(8'($urandom));
    foreach (exp[i]) begin
      b = exp[i];
      send(b, 0, 0);
    end
    cyc(5);
    checks++;
    if (cap.size() != exp.size() || pop_cycles != exp.size()) begin
      errors++;
      $display("FAIL stream_count got=%0d cyc=%0d want %0d",
               cap.size(), pop_cycles, exp.size());
    end
    for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp[i]) begin
        errors++;
        $display("FAIL stream_byte%0d got=%h want %h",
                 i, cap[i], exp[i]);
      end
    end
    checks++;
    if (overflow !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL stream_flags ovf=%b rdy=%b want 0/0",
               overflow, ready);
    end
    nextdata_n = 1'b1;
  endtask

  task automatic test_errors();
    int n;
    do_reset();
    send(8'h1C, 1, 0);
    send(8'h16, 0, 1);
    n = 2;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) != 0)
        send(8'($urandom), 1, 0);
      else
        send(8'($urandom), $urandom_range(0, 1) != 0, 1);
      n++;
    end
    checks++;
    if (err_cnt != n) begin
      errors++;
      $display("FAIL err_pulses got=%0d want %0d", err_cnt, n);
    end
    checks++;
    if (ready !== 1'b0 || data !== 8'h00) begin
      errors++;
      $display("FAIL err_ready got=%b/%h want 0/00", ready, data);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++)
      send(8'(i), 0, 0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_at8 got=%b want 0", overflow);
    end
    send(8'h09, 0, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_at9 got=%b want 1", overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (ready !== 1'b1 || data !== 8'(i)) begin
        errors++;
        $display("FAIL ovf_pop%0d rdy=%b data=%h want 1/%h",
                 i, ready, data, 8'(i));
      end
      pop1();
    end
    checks++;
    if (ready !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_end rdy=%b ovf=%b want 0/1",
               ready, overflow);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] b;
    logic [7:0] want;
    bit         ovf;
    int         kind;
    int         nerr;
    do_reset();
    ovf = 0;
    nerr = 0;
    for (int k = 0; k < 30; k++) begin
      b = 8'($urandom);
      kind = $urandom_range(0, 7);
      if (kind == 6) begin
        send(b, 1, 0);
        nerr++;
      end else if (kind == 7) begin
        send(b, 0, 1);
        nerr++;
      end else begin
        send(b, 0, 0);
        if (q.size() < DEPTH)
          q.push_back(b);
        else
          ovf = 1;
      end
      want = (q.size() != 0) ? q[0] : 8'h00;
      checks++;
      if (ready !== (q.size() != 0) || data !== want ||
          overflow !== ovf || err_cnt != nerr) begin
        errors++;
        $display("FAIL rand%0d rdy=%b d=%h ovf=%b e=%0d want %b/%h/%b/%0d",
                 k, ready, data, overflow, err_cnt,
                 q.size() != 0, want, ovf, nerr);
      end
      if (q.size() != 0 && $urandom_range(0, 2) != 0) begin
        pop1();
        void'(q.pop_front());
      end
    end
  endtask

  task automatic test_rst_midframe();
    do_reset();
    nextdata_n = 1'b0;
    send_bits(mk(8'hA5, 0, 0), 5);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    cap.delete();
    err_cnt = 0;
    send(8'h45, 0, 0);
    cyc(5);
    checks++;
    if (cap.size() != 1 || (cap.size() == 1 && cap[0] !== 8'h45)) begin
      errors++;
      $display("FAIL midrst_bytes n=%0d first=%h want 1/45",
               cap.size(), cap.size() != 0 ? cap[0] : 8'h00);
    end
    checks++;
    if (err_cnt != 0) begin
      errors++;
      $display("FAIL midrst_err got=%0d want 0", err_cnt);
    end
    nextdata_n = 1'b1;
  endtask

`ifdef PS2_RX_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    nextdata_n = 1'b0;
    send_bits(mk(8'h3B, 0, 0), 4);
    cyc(TO + 10);
    checks++;
    if (err_cnt != 1) begin
      errors++;
      $display("FAIL timeout_err got=%0d want 1", err_cnt);
    end
    send(8'h16, 0, 0);
    cyc(5);
    checks++;
    if (cap.size() != 1 || (cap.size() == 1 && cap[0] !== 8'h16)) begin
      errors++;
      $display("FAIL timeout_next n=%0d want one byte 16",
               cap.size());
    end
    nextdata_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_hold_pop();
    test_stream();
    test_errors();
    test_overflow();
    test_random();
    test_rst_midframe();
`ifdef PS2_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
PS/2 device-to-host serial receiver with an on-chip byte FIFO. It samples the keyboard's ps2_clk/ps2_data lines, deframes 11-bit frames, checks start, parity and stop bits, and queues good scan-code bytes. It sits directly upstream of the scan-code display/FSM stage. That stage consumes bytes through the data/ready/nextdata_n pop interface, and often ties nextdata_n permanently low.

Parameters:
FIFO_DEPTH, 8, number of byte entries; must be a power of two and at least 2
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted (used only with PS2_RX_TIMEOUT_EN)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  reset, asynchronous, active-high
ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk
ps2_data  input  1  raw PS/2 data line, asynchronous to clk
nextdata_n  input  1  active-low pop request; effective only while ready=1
data  output  8  FIFO head byte; 8'h00 when FIFO is empty
ready  output  1  FIFO non-empty
overflow  output  1  sticky flag: a good byte was dropped because the FIFO was full
frame_err  output  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset is asynchronous on rst, using clock clk. Reset values: FSM=IDLE, bit counter=0, shift register=0, FIFO pointers=0, ready=0, data=8'h00, overflow=0, frame_err=0. Synchronizer flops reset to 1 (idle line level).
- Input sampling:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - A third flop on ps2_clk provides edge history.
  - fall = prev_clk & ~sync_clk.
  - ps2_data is sampled (synchronized value) only in the fall cycle.
  - Requirement on the line: each ps2_clk phase lasts at least 4 clk cycles.
- Frame format: start(0), d0..d7 LSB first, parity (odd over d0..d7 plus parity bit), stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA with bitcnt=0. On fall with data=1, stay in IDLE (glitch or no start bit).
  - DATA: each fall shifts the sample into bit[bitcnt] and increments bitcnt. After the 8th bit, go to PARITY.
  - PARITY: on fall, latch the parity bit and go to STOP.
  - STOP: on fall, go to IDLE. If stop=1 and parity is odd, push the byte. Otherwise pulse frame_err for 1 cycle and do not push.
- Latency: the pushed byte appears on data, with ready=1, on the clk edge after the stop-bit fall cycle.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide. The extra MSB distinguishes full from empty; pointers wrap naturally.
  - ready = (wptr != rptr).
  - A pop occurs at a clk edge when ready=1 and nextdata_n=0. A pop while empty is ignored.
  - With nextdata_n held low, ready is high for exactly 1 cycle per byte (or back-to-back cycles if several bytes are queued).
- Boundary cases:
  - Push while full with no pop: byte discarded, overflow←1. overflow holds until rst.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle while empty: push only.
  - rst mid-frame: partial frame discarded; FIFO contents lost.
  - frame_err and push never occur in the same cycle.

Optional Feature:
Macro PS2_RX_TIMEOUT_EN.
- Defined: a counter runs while FSM≠IDLE, cleared on every fall. On reaching TIMEOUT_CYCLES, the FSM returns to IDLE, frame_err pulses for 1 cycle, and the partial byte is discarded.
- Undefined: the counter is absent; an incomplete frame waits indefinitely for further edges. TIMEOUT_CYCLES is unused.

Decomposition:
- Package ps2_pkg holds:
  - FSM state encodings: IDLE=2'b00, DATA=2'b01, PARITY=2'b10, STOP=2'b11.
  - DATA_BITS=8 and FRAME_BITS=11.
  - PS2_BREAK=8'hF0 and PS2_EXTEND=8'hE0, for downstream consumers.
- One sub-module, ps2_byte_fifo: a synchronous FIFO with push/pop/full/empty and an overflow flag. It is instantiated once.

Test Plan:
1. nextdata_n=1; send 0x1C (parity 0) → ready=1 and data=0x1C, held. Pulse nextdata_n low for 1 cycle → ready=0, data=8'h00.
2. nextdata_n tied 0; send 0xF0 (parity 1), then 0x1C → ready pulses for 1 cycle with data=0xF0, later pulses for 1 cycle with data=0x1C; overflow=0.
3. Send 0x1C with parity bit 1, then 0x16 with stop bit 0 → two frame_err pulses; ready stays 0.
4. nextdata_n=1; send 0x01..0x09 → overflow=0 after the 8th byte and 1 after the 9th. Eight pops return 0x01..0x08, then ready=0; overflow stays 1.
5. Assert rst after 5 bits of a frame; release it, then send full frame 0x45 → exactly one byte, 0x45; frame_err never pulses.
6. (PS2_RX_TIMEOUT_EN) Send 4 bits, then hold ps2_clk high for TIMEOUT_CYCLES+10 cycles → one frame_err pulse. A following frame 0x16 is received correctly.
